id_ex_stage: RTL and testbench

ID/EX pipeline register and operand-forwarding stage directly upstream of the ALU. Captures decoded operands and control from the decode stage, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and drives the ALU's `in1`, `in2` and `ALU_ctrl` inputs. Detects load-use hazards and inserts bubbles. Honours downstream stall and branch flush.

---
 rtl/riscv_pkg.sv | 40 ++++
 rtl/fwd_mux.sv | 30 +++
 rtl/id_ex_stage.sv | 193 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and types for the integer pipeline: datapath widths, ALU op codes,
// EX-stage control layout and its bubble encoding.
// Pure definitions; no latency or flow-control behaviour of its own.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int RAW  = 5;

    // ALU operation codes as presented on alu_ctrl
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_SLL  = 4'h2;
    localparam logic [3:0] ALU_SLT  = 4'h3;
    localparam logic [3:0] ALU_SLTU = 4'h4;
    localparam logic [3:0] ALU_XOR  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_OR   = 4'h8;
    localparam logic [3:0] ALU_AND  = 4'h9;

    // Registered control carried by the EX stage
    typedef struct packed {
        logic       valid;
        logic [3:0] alu_ctrl;
        logic       reg_write;
        logic       mem_read;
    } ex_ctrl_t;

    // A bubble does nothing: no write-back, no memory access, harmless ADD
    localparam ex_ctrl_t EX_CTRL_BUBBLE = '{valid: 1'b0, alu_ctrl: ALU_ADD,
                                            reg_write: 1'b0, mem_read: 1'b0};

    // True when a producer writing rd supplies source register rs; x0 never matches
    function automatic logic fwd_hit(input logic           we,
                                     input logic [RAW-1:0] rd,
                                     input logic [RAW-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Resolves one EX operand: EX/MEM result, else MEM/WB result, else the stored value.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is consumed.
module fwd_mux #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int RAW  = riscv_pkg::RAW
) (
    input  logic [RAW-1:0]  rs_addr_i,
    input  logic [XLEN-1:0] stored_i,
    input  logic [RAW-1:0]  exm_rd_addr_i,
    input  logic            exm_reg_write_i,
    input  logic [XLEN-1:0] exm_result_i,
    input  logic [RAW-1:0]  wb_rd_addr_i,
    input  logic            wb_reg_write_i,
    input  logic [XLEN-1:0] wb_result_i,
    output logic [XLEN-1:0] value_o
);
    import riscv_pkg::*;

    // Younger producer (EX/MEM) takes precedence over the older one (MEM/WB)
    always_comb begin
        value_o = stored_i;
        if (fwd_hit(exm_reg_write_i, exm_rd_addr_i, rs_addr_i)) begin
            value_o = exm_result_i;
        end else if (fwd_hit(wb_reg_write_i, wb_rd_addr_i, rs_addr_i)) begin
            value_o = wb_result_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding feeding the ALU, plus load-use bubble insertion.
// Latency: one cycle from acceptance to ALU drive; ALU operands are resolved combinationally in EX.
// Backpressure: id_ready drops on ex_stall, flush or load-use; ex_stall holds EX, flush overrides it.
module id_ex_stage #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int RAW  = riscv_pkg::RAW
) (
    input  logic            clk,
    input  logic            rst,
    // decode side
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [RAW-1:0]  id_rs1_addr,
    input  logic [RAW-1:0]  id_rs2_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_pc,
    input  logic            id_use_imm,
    input  logic            id_use_pc,
    input  logic [3:0]      id_alu_ctrl,
    input  logic [RAW-1:0]  id_rd_addr,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    // pipeline control
    input  logic            flush,
    input  logic            ex_stall,
    // forwarding sources
    input  logic [RAW-1:0]  exm_rd_addr,
    input  logic            exm_reg_write,
    input  logic [XLEN-1:0] exm_result,
    input  logic [RAW-1:0]  wb_rd_addr,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    // EX outputs
    output logic            ex_valid,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] ex_store_data,
    output logic [RAW-1:0]  ex_rd_addr,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            load_use_stall
);
    import riscv_pkg::*;

    ex_ctrl_t        ctrl_q, ctrl_d;
    logic [RAW-1:0]  rd_q, rd_d;
    logic [RAW-1:0]  rs1_addr_q, rs1_addr_d;
    logic [RAW-1:0]  rs2_addr_q, rs2_addr_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            use_imm_q, use_imm_d;
    logic            use_pc_q, use_pc_d;

    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic [XLEN-1:0] rs1_cap, rs2_cap;
    logic            do_hold, do_capture, do_bubble;

    fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd_rs1 (
        .rs_addr_i       (rs1_addr_q),
        .stored_i        (rs1_q),
        .exm_rd_addr_i   (exm_rd_addr),
        .exm_reg_write_i (exm_reg_write),
        .exm_result_i    (exm_result),
        .wb_rd_addr_i    (wb_rd_addr),
        .wb_reg_write_i  (wb_reg_write),
        .wb_result_i     (wb_result),
        .value_o         (rs1_fwd)
    );

    fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd_rs2 (
        .rs_addr_i       (rs2_addr_q),
        .stored_i        (rs2_q),
        .exm_rd_addr_i   (exm_rd_addr),
        .exm_reg_write_i (exm_reg_write),
        .exm_result_i    (exm_result),
        .wb_rd_addr_i    (wb_rd_addr),
        .wb_reg_write_i  (wb_reg_write),
        .wb_result_i     (wb_result),
        .value_o         (rs2_fwd)
    );

    // Hazard detection, operand select and decode handshake, all from EX state plus buses
    always_comb begin
        // rs2 match is checked even for immediate forms: cheaper than qualifying it
        load_use_stall = ctrl_q.valid & ctrl_q.mem_read & id_valid & (rd_q != '0) &
                         ((rd_q == id_rs1_addr) | (rd_q == id_rs2_addr));
        id_ready       = ~load_use_stall & ~ex_stall & ~flush;
        alu_in1        = use_pc_q  ? pc_q  : rs1_fwd;
        alu_in2        = use_imm_q ? imm_q : rs2_fwd;
        ex_store_data  = rs2_fwd;
    end

    // Capture-time bypass: the register file is written this same cycle, so its read is stale
    always_comb begin
        rs1_cap = fwd_hit(wb_reg_write, wb_rd_addr, id_rs1_addr) ? wb_result : id_rs1_data;
        rs2_cap = fwd_hit(wb_reg_write, wb_rd_addr, id_rs2_addr) ? wb_result : id_rs2_data;
    end

    // Next-state selection: flush > stall hold > load-use bubble > capture > idle bubble
    always_comb begin
        do_hold    = ~flush & ex_stall;
        do_capture = ~flush & ~ex_stall & ~load_use_stall & id_valid;
        do_bubble  = ~do_hold & ~do_capture;

        ctrl_d     = ctrl_q;
        rd_d       = rd_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        use_imm_d  = use_imm_q;
        use_pc_d   = use_pc_q;

        if (do_hold) begin
            // Latch forwarded operands so a producer retiring mid-hold is not lost
            rs1_d = rs1_fwd;
            rs2_d = rs2_fwd;
        end

        if (do_capture) begin
            ctrl_d.valid     = 1'b1;
            ctrl_d.alu_ctrl  = id_alu_ctrl;
            ctrl_d.reg_write = id_reg_write;
            ctrl_d.mem_read  = id_mem_read;
            rd_d             = id_rd_addr;
            rs1_addr_d       = id_rs1_addr;
            rs2_addr_d       = id_rs2_addr;
            rs1_d            = rs1_cap;
            rs2_d            = rs2_cap;
            imm_d            = id_imm;
            pc_d             = id_pc;
            use_imm_d        = id_use_imm;
            use_pc_d         = id_use_pc;
        end

        if (do_bubble) begin
            ctrl_d     = EX_CTRL_BUBBLE;
            rd_d       = '0;
            rs1_addr_d = '0;
            rs2_addr_d = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            imm_d      = '0;
            pc_d       = '0;
            use_imm_d  = 1'b0;
            use_pc_d   = 1'b0;
        end
    end

    // Stage register; synchronous reset clears to a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= EX_CTRL_BUBBLE;
            rd_q       <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            use_imm_q  <= 1'b0;
            use_pc_q   <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            rd_q       <= rd_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            use_imm_q  <= use_imm_d;
            use_pc_q   <= use_pc_d;
        end
    end

    // Registered outputs come straight from the stage register
    always_comb begin
        ex_valid     = ctrl_q.valid;
        alu_ctrl     = ctrl_q.alu_ctrl;
        ex_reg_write = ctrl_q.reg_write;
        ex_mem_read  = ctrl_q.mem_read;
        ex_rd_addr   = rd_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic vs a reference model.
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic        id_use_imm, id_use_pc, id_reg_write, id_mem_read;
    logic [3:0]  id_alu_ctrl;
    logic        flush, ex_stall;
    logic [4:0]  exm_rd_addr, wb_rd_addr;
    logic        exm_reg_write, wb_reg_write;
    logic [31:0] exm_result, wb_result;
    logic        ex_valid, ex_reg_write, ex_mem_read, load_use_stall;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [3:0]  alu_ctrl;
    logic [4:0]  ex_rd_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_pc(id_pc),
        .id_use_imm(id_use_imm), .id_use_pc(id_use_pc),
        .id_alu_ctrl(id_alu_ctrl), .id_rd_addr(id_rd_addr),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .ex_stall(ex_stall),
        .exm_rd_addr(exm_rd_addr), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .ex_valid(ex_valid), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
        .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .load_use_stall(load_use_stall)
    );

    // Reference model: the instruction currently occupying EX, as a plain record
    typedef struct {
        logic        valid;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw, mr;
        logic [4:0]  rs1a, rs2a;
        logic [31:0] rs1v, rs2v, imm, pc;
        logic        uimm, upc;
    } ex_rec_t;

    ex_rec_t m, mn;

    function automatic ex_rec_t empty_rec();
        ex_rec_t r;
        r = '{valid: 0, ctrl: 0, rd: 0, rw: 0, mr: 0, rs1a: 0, rs2a: 0,
              rs1v: 0, rs2v: 0, imm: 0, pc: 0, uimm: 0, upc: 0};
        return r;
    endfunction

    // Newest producer wins; register 0 is hardwired and never supplied by a producer
    function automatic logic [31:0] m_resolve(input logic [4:0] a, input logic [31:0] stored);
        if (a == 0) return stored;
        if (exm_reg_write && exm_rd_addr == a) return exm_result;
        if (wb_reg_write && wb_rd_addr == a) return wb_result;
        return stored;
    endfunction

    function automatic logic m_lus();
        return m.valid && m.mr && id_valid && m.rd != 0 &&
               (m.rd == id_rs1_addr || m.rd == id_rs2_addr);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; id_valid = 0; flush = 0; ex_stall = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_pc = 0;
        id_use_imm = 0; id_use_pc = 0; id_reg_write = 0; id_mem_read = 0; id_alu_ctrl = 0;
        exm_rd_addr = 0; exm_reg_write = 0; exm_result = 0;
        wb_rd_addr = 0; wb_reg_write = 0; wb_result = 0;
    endtask

    task automatic present(input logic [4:0] rs1, input logic [31:0] rs1d,
                           input logic [4:0] rs2, input logic [31:0] rs2d,
                           input logic [31:0] imm, input logic [31:0] pc,
                           input logic uimm, input logic upc, input logic [3:0] ctrl,
                           input logic [4:0] rd, input logic rw, input logic mr);
        id_valid = 1; id_rs1_addr = rs1; id_rs1_data = rs1d; id_rs2_addr = rs2; id_rs2_data = rs2d;
        id_imm = imm; id_pc = pc; id_use_imm = uimm; id_use_pc = upc; id_alu_ctrl = ctrl;
        id_rd_addr = rd; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        present(5'd1, 32'h1234, 5'd2, 32'h5678, 32'h9, 32'h400, 1'b0, 1'b0, ALU_XOR, 5'd3, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
            total++; if (alu_ctrl !== 4'h0) begin bad++; $display("FAIL reset_alu_ctrl got=%h exp=0", alu_ctrl); end
            total++; if (alu_in1 !== 32'h0) begin bad++; $display("FAIL reset_alu_in1 got=%h exp=0", alu_in1); end
            total++; if (alu_in2 !== 32'h0) begin bad++; $display("FAIL reset_alu_in2 got=%h exp=0", alu_in2); end
        end
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        idle();
        present(5'd1, 32'h8, 5'd2, 32'h8, 0, 0, 1'b0, 1'b0, ALU_ADD, 5'd5, 1'b1, 1'b0);
        tick();
        total++; if (ex_rd_addr !== 5'd5 || ex_reg_write !== 1'b1) begin
            bad++; $display("FAIL b2b_producer got rd=%0d rw=%b exp rd=5 rw=1", ex_rd_addr, ex_reg_write); end
        idle();
        present(5'd5, 32'h0, 5'd6, 32'h3, 0, 0, 1'b0, 1'b0, ALU_ADD, 5'd8, 1'b1, 1'b0);
        tick();
        idle();
        exm_rd_addr = 5; exm_reg_write = 1; exm_result = 32'h10;
        #1;
        total++; if (alu_in1 !== 32'h10) begin bad++; $display("FAIL b2b_exm got=%h exp=00000010", alu_in1); end
        idle();
        present(5'd5, 32'h0, 5'd6, 32'h3, 0, 0, 1'b0, 1'b0, ALU_ADD, 5'd8, 1'b1, 1'b0);
        tick();
        idle();
        wb_rd_addr = 5; wb_reg_write = 1; wb_result = 32'h10;
        #1;
        total++; if (alu_in1 !== 32'h10) begin bad++; $display("FAIL b2b_wb got=%h exp=00000010", alu_in1); end
        total++; if (alu_in2 !== 32'h3) begin bad++; $display("FAIL b2b_wb_rs2 got=%h exp=00000003", alu_in2); end
    endtask

    task automatic test_double_match();
        idle();
        present(5'd7, 32'h123, 5'd0, 32'h0, 0, 0, 1'b0, 1'b0, ALU_OR, 5'd9, 1'b1, 1'b0);
        tick();
        idle();
        exm_rd_addr = 7; exm_reg_write = 1; exm_result = 32'hAA;
        wb_rd_addr = 7; wb_reg_write = 1; wb_result = 32'hBB;
        #1;
        total++; if (alu_in1 !== 32'hAA) begin bad++; $display("FAIL double_match got=%h exp=000000aa", alu_in1); end
        idle();
        present(5'd0, 32'h0, 5'd0, 32'h0, 0, 0, 1'b0, 1'b0, ALU_OR, 5'd9, 1'b1, 1'b0);
        tick();
        idle();
        exm_rd_addr = 0; exm_reg_write = 1; exm_result = 32'hAA;
        wb_rd_addr = 0; wb_reg_write = 1; wb_result = 32'hBB;
        #1;
        total++; if (alu_in1 !== 32'h0) begin bad++; $display("FAIL x0_no_fwd_in1 got=%h exp=00000000", alu_in1); end
        total++; if (ex_store_data !== 32'h0) begin bad++; $display("FAIL x0_no_fwd_rs2 got=%h exp=00000000", ex_store_data); end
    endtask

    task automatic test_load_use();
        idle();
        present(5'd1, 32'h1000, 5'd2, 32'h0, 32'h4, 0, 1'b1, 1'b0, ALU_ADD, 5'd3, 1'b1, 1'b1);
        tick();
        present(5'd1, 32'h5, 5'd3, 32'h0, 0, 0, 1'b0, 1'b0, ALU_ADD, 5'd4, 1'b1, 1'b0);
        #1;
        total++; if (load_use_stall !== 1'b1) begin bad++; $display("FAIL lu_stall_on got=%b exp=1", load_use_stall); end
        total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL lu_ready_off got=%b exp=0", id_ready); end
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%b exp=0", ex_valid); end
        total++; if (load_use_stall !== 1'b0) begin bad++; $display("FAIL lu_one_cycle got=%b exp=0", load_use_stall); end
        total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL lu_ready_back got=%b exp=1", id_ready); end
        exm_rd_addr = 3; exm_reg_write = 1; exm_result = 32'h77;
        tick();
        #1;
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL lu_add_valid got=%b exp=1", ex_valid); end
        total++; if (alu_in2 !== 32'h77) begin bad++; $display("FAIL lu_add_in2 got=%h exp=00000077", alu_in2); end
        total++; if (alu_in1 !== 32'h5) begin bad++; $display("FAIL lu_add_in1 got=%h exp=00000005", alu_in1); end
    endtask

    task automatic test_stall_hold();
        idle();
        present(5'd9, 32'h0, 5'd0, 32'h0, 0, 0, 1'b0, 1'b0, ALU_ADD, 5'd10, 1'b1, 1'b0);
        tick();
        idle();
        ex_stall = 1;
        exm_rd_addr = 9; exm_reg_write = 1; exm_result = 32'h55;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (alu_in1 !== 32'h55) begin bad++; $display("FAIL stall_in1_c%0d got=%h exp=00000055", c, alu_in1); end
            total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL stall_ready_c%0d got=%b exp=0", c, id_ready); end
            tick();
            exm_reg_write = 0; exm_rd_addr = 0; exm_result = 0;
            wb_rd_addr = (c == 0) ? 5'd9 : 5'd0;
            wb_reg_write = (c == 0);
            wb_result = (c == 0) ? 32'h55 : 32'h0;
        end
        ex_stall = 0;
        #1;
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b exp=1", ex_valid); end
        total++; if (alu_in1 !== 32'h55) begin bad++; $display("FAIL stall_release_in1 got=%h exp=00000055", alu_in1); end
        tick();
    endtask

    task automatic test_flush_stall();
        idle();
        present(5'd1, 32'h1, 5'd2, 32'h2, 0, 0, 1'b0, 1'b0, ALU_SUB, 5'd6, 1'b1, 1'b0);
        tick();
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_valid got=%b exp=1", ex_valid); end
        flush = 1; ex_stall = 1;
        #1;
        total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", id_ready); end
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", ex_valid); end
        total++; if (ex_reg_write !== 1'b0) begin bad++; $display("FAIL flush_rw got=%b exp=0", ex_reg_write); end
        idle();
    endtask

    task automatic test_imm();
        idle();
        present(5'd1, 32'h10, 5'd4, 32'h1111, 32'hFFFFF800, 32'h80, 1'b1, 1'b0, ALU_ADD, 5'd2, 1'b1, 1'b0);
        tick();
        idle();
        exm_rd_addr = 4; exm_reg_write = 1; exm_result = 32'h2222;
        #1;
        total++; if (alu_in2 !== 32'hFFFFF800) begin bad++; $display("FAIL imm_in2 got=%h exp=fffff800", alu_in2); end
        total++; if (ex_store_data !== 32'h2222) begin bad++; $display("FAIL imm_store got=%h exp=00002222", ex_store_data); end
        total++; if (alu_in1 !== 32'h10) begin bad++; $display("FAIL imm_in1 got=%h exp=00000010", alu_in1); end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2, es;
        logic        elus;
        m = empty_rec();
        for (int i = 0; i < 1500; i++) begin
            rst          = (i == 0) || ($urandom_range(0, 63) == 0);
            id_valid     = $urandom_range(0, 3) != 0;
            flush        = $urandom_range(0, 15) == 0;
            ex_stall     = $urandom_range(0, 3) == 0;
            id_rs1_addr  = 5'($urandom_range(0, 3));
            id_rs2_addr  = 5'($urandom_range(0, 3));
            id_rd_addr   = 5'($urandom_range(0, 3));
            id_rs1_data  = $urandom;
            id_rs2_data  = $urandom;
            id_imm       = $urandom;
            id_pc        = $urandom;
            id_use_imm   = 1'($urandom_range(0, 1));
            id_use_pc    = 1'($urandom_range(0, 1));
            id_alu_ctrl  = 4'($urandom_range(0, 15));
            id_reg_write = 1'($urandom_range(0, 1));
            id_mem_read  = $urandom_range(0, 2) == 0;
            exm_rd_addr  = 5'($urandom_range(0, 3));
            exm_reg_write = 1'($urandom_range(0, 1));
            exm_result   = $urandom;
            wb_rd_addr   = 5'($urandom_range(0, 3));
            wb_reg_write = 1'($urandom_range(0, 1));
            wb_result    = $urandom;
            #1;
            elus = m_lus();
            e1 = m.upc ? m.pc : m_resolve(m.rs1a, m.rs1v);
            es = m_resolve(m.rs2a, m.rs2v);
            e2 = m.uimm ? m.imm : es;
            if (i > 0) begin
                total++; if (ex_valid !== m.valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, ex_valid, m.valid); end
                total++; if (alu_ctrl !== m.ctrl) begin bad++; $display("FAIL rnd_ctrl cyc=%0d got=%h exp=%h", i, alu_ctrl, m.ctrl); end
                total++; if (ex_rd_addr !== m.rd) begin bad++; $display("FAIL rnd_rd cyc=%0d got=%0d exp=%0d", i, ex_rd_addr, m.rd); end
                total++; if (ex_reg_write !== m.rw) begin bad++; $display("FAIL rnd_rw cyc=%0d got=%b exp=%b", i, ex_reg_write, m.rw); end
                total++; if (ex_mem_read !== m.mr) begin bad++; $display("FAIL rnd_mr cyc=%0d got=%b exp=%b", i, ex_mem_read, m.mr); end
                total++; if (alu_in1 !== e1) begin bad++; $display("FAIL rnd_in1 cyc=%0d got=%h exp=%h", i, alu_in1, e1); end
                total++; if (alu_in2 !== e2) begin bad++; $display("FAIL rnd_in2 cyc=%0d got=%h exp=%h", i, alu_in2, e2); end
                total++; if (ex_store_data !== es) begin bad++; $display("FAIL rnd_store cyc=%0d got=%h exp=%h", i, ex_store_data, es); end
                total++; if (load_use_stall !== elus) begin bad++; $display("FAIL rnd_lus cyc=%0d got=%b exp=%b", i, load_use_stall, elus); end
                total++; if (id_ready !== (!elus && !ex_stall && !flush)) begin
                    bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, id_ready, !elus && !ex_stall && !flush); end
            end
            if (rst || flush) begin
                mn = empty_rec();
            end else if (ex_stall) begin
                mn = m;
                mn.rs1v = m_resolve(m.rs1a, m.rs1v);
                mn.rs2v = es;
            end else if (elus || !id_valid) begin
                mn = empty_rec();
            end else begin
                mn.valid = 1; mn.ctrl = id_alu_ctrl; mn.rd = id_rd_addr;
                mn.rw = id_reg_write; mn.mr = id_mem_read;
                mn.rs1a = id_rs1_addr; mn.rs2a = id_rs2_addr;
                mn.rs1v = (wb_reg_write && id_rs1_addr != 0 && wb_rd_addr == id_rs1_addr) ? wb_result : id_rs1_data;
                mn.rs2v = (wb_reg_write && id_rs2_addr != 0 && wb_rd_addr == id_rs2_addr) ? wb_result : id_rs2_data;
                mn.imm = id_imm; mn.pc = id_pc; mn.uimm = id_use_imm; mn.upc = id_use_pc;
            end
            tick();
            m = mn;
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_back_to_back();
        test_double_match();
        test_load_use();
        test_stall_hold();
        test_flush_stall();
        test_imm();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
